// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types for the dmem bus arbiter: FSM states, grant encoding and LED address default.
package dmem_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} arb_state_t;
  typedef enum logic       {GNT_M0, GNT_M1}        grant_t;

  localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_0100;

  function automatic logic [1:0] grant_onehot(input grant_t g);
    return (g == GNT_M0) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Requester (M0/M1), dmem and LED signals of the arbiter, bundled with arbiter-side and requester-side views.
interface dmem_bus_arbiter_if #(
  parameter int MEM_AW = 8
);
  logic              m0_valid, m0_ready, m0_we, m0_rsp_valid;
  logic [31:0]       m0_addr, m0_wdata, m0_rdata;
  logic              m1_valid, m1_ready, m1_we, m1_rsp_valid;
  logic [31:0]       m1_addr, m1_wdata, m1_rdata;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [7:0]        led;

  modport slave (
    input  m0_valid, m0_we, m0_addr, m0_wdata,
    output m0_ready, m0_rsp_valid, m0_rdata,
    input  m1_valid, m1_we, m1_addr, m1_wdata,
    output m1_ready, m1_rsp_valid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output led
  );

  modport master (
    output m0_valid, m0_we, m0_addr, m0_wdata,
    input  m0_ready, m0_rsp_valid, m0_rdata,
    output m1_valid, m1_we, m1_addr, m1_wdata,
    input  m1_ready, m1_rsp_valid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  led
  );
endinterface

// File: rtl/dmem_bus_arbiter_arb2_grant.sv
// Two-way grant logic. ARB_RR_EN selects round-robin (with last-grant register); otherwise M0 has fixed priority.
module arb2_grant
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

`ifdef ARB_RR_EN
  grant_t r_last_grant;

  // Contention goes to whoever was not served last; a lone request always wins.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = (r_last_grant == GNT_M1) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_last_grant <= GNT_M1;
    else if (i_accept && (|o_gnt)) r_last_grant <= o_gnt[1] ? GNT_M1 : GNT_M0;
  end
`else
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[0])      o_gnt = 2'b01;
    else if (i_req[1]) o_gnt = 2'b10;
  end

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, clk, reset, i_accept};
`endif

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Shares single-port dmem between CPU (M0) and debug/loader (M1) and owns the LED register.
// Optional macro ARB_RR_EN: round-robin arbitration instead of M0 fixed priority.
module dmem_bus_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          MEM_AW   = 8,
  parameter logic [31:0] LED_ADDR = LED_ADDR_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  dmem_bus_arbiter_if.slave bus
);

  arb_state_t        r_state;
  grant_t            r_gnt;
  logic              r_we, r_is_led, r_mem_en, r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [1:0]        r_rsp_v;
  logic [7:0]        r_led;

  logic [1:0]  w_req, w_gnt;
  logic        w_idle, w_hs, w_sel_m1, w_we, w_is_led;
  logic [31:0] w_addr, w_wdata, w_rdata;

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = {bus.m1_valid, bus.m0_valid};
  assign w_hs   = w_idle & (|w_req);

  arb2_grant u_grant (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_req),
    .i_accept (w_hs),
    .o_gnt    (w_gnt)
  );

  assign bus.m0_ready = w_idle & w_gnt[0];
  assign bus.m1_ready = w_idle & w_gnt[1];

  assign w_sel_m1 = w_gnt[1];
  assign w_we     = w_sel_m1 ? bus.m1_we    : bus.m0_we;
  assign w_addr   = w_sel_m1 ? bus.m1_addr  : bus.m0_addr;
  assign w_wdata  = w_sel_m1 ? bus.m1_wdata : bus.m0_wdata;
  assign w_is_led = (w_addr == LED_ADDR);

  // dmem strobes are computed at the handshake so they come out of flops during MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gnt       <= GNT_M0;
      r_we        <= 1'b0;
      r_is_led    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_v     <= 2'b00;
      r_led       <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_v <= 2'b00;
          if (w_hs) begin
            r_state     <= S_MEM;
            r_gnt       <= w_sel_m1 ? GNT_M1 : GNT_M0;
            r_we        <= w_we;
            r_is_led    <= w_is_led;
            r_mem_en    <= ~w_is_led;
            r_mem_we    <= ~w_is_led & w_we;
            r_mem_addr  <= w_addr[MEM_AW+1:2];
            r_mem_wdata <= w_wdata;
          end
        end
        S_MEM: begin
          if (r_is_led && r_we) r_led <= r_mem_wdata[7:0];
          r_mem_en    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_rsp_v     <= grant_onehot(r_gnt);
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_rsp_v <= 2'b00;
          r_state <= S_IDLE;
        end
        default: begin
          r_rsp_v <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read data arrives from dmem during RESP, so the response mux stays combinational.
  assign w_rdata = r_we ? 32'h0 : (r_is_led ? {24'h0, r_led} : bus.mem_rdata);

  assign bus.m0_rsp_valid = r_rsp_v[0];
  assign bus.m1_rsp_valid = r_rsp_v[1];
  assign bus.m0_rdata     = r_rsp_v[0] ? w_rdata : 32'h0;
  assign bus.m1_rdata     = r_rsp_v[1] ? w_rdata : 32'h0;
  assign bus.mem_en       = r_mem_en;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.led          = r_led;

endmodule
